// File: rtl/ex_stage_if.sv
// Bundle of everything the execute stage exchanges with its neighbours:
// the decode->EX handshake, the EX->MEM handshake, the forwarding bundle
// to decode, the data-SRAM request and a small divider debug view.
//
// Handshake rule (both links): a transfer happens on a rising edge where
// the sender's valid and the receiver's allowin are both high; valid never
// depends on allowin from the same link, and the sender's payload holds
// while valid is high and allowin is low.
//
// Modports:
//   slave  - the execute stage itself
//   master - the surrounding pipeline / testbench
interface ex_stage_if;
  logic         es_allowin;
  logic         ds2es_valid;
  logic [142:0] ds2es_bus;
  logic         es2ms_valid;
  logic [75:0]  es2ms_bus;
  logic         ms_allowin;
  logic [38:0]  es_rf_zip;
  logic         data_sram_en;
  logic [3:0]   data_sram_we;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;
  logic [5:0]   dbg_cnt;
  logic         dbg_div_done;

  modport slave (
    input  ds2es_valid, ds2es_bus, ms_allowin,
    output es_allowin, es2ms_valid, es2ms_bus, es_rf_zip,
           data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
           dbg_cnt, dbg_div_done
  );

  modport master (
    output ds2es_valid, ds2es_bus, ms_allowin,
    input  es_allowin, es2ms_valid, es2ms_bus, es_rf_zip,
           data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
           dbg_cnt, dbg_div_done
  );
endinterface

// File: rtl/ex_stage.sv
// Execute stage of the five-stage in-order pipeline.
// Holds one instruction, computes single-cycle ALU results, runs a 34-cycle
// radix-2 restoring divider for div/mod, issues data-SRAM requests on the
// handoff cycle, and packs the EX->MEM bus and the forwarding bundle.
//
// Ports:
//   clk   - sole clock, rising edge
//   reset - asynchronous, active-high
//   io    - ex_stage_if.slave (decode/MEM handshakes, forwarding, SRAM,
//           divider debug: dbg_cnt, dbg_div_done)
module ex_stage (
  input  logic        clk,
  input  logic        reset,
  ex_stage_if.slave   io
);
  logic         es_valid;
  logic [142:0] ds_bus_r;
  logic         es_ready_go;

  // decoded fields of the pipeline register
  logic [3:0]  alu_op;
  logic [31:0] src1, src2, st_data, pc;
  logic        mem_we, mem_sign, res_from_mem, rf_we;
  logic [1:0]  mem_size;
  logic [4:0]  rf_waddr;

  assign {alu_op, src1, src2, st_data, mem_we, mem_size, mem_sign,
          res_from_mem, rf_we, rf_waddr, pc} = ds_bus_r;

  logic is_div, div_signed;
  assign is_div     = alu_op[3] & alu_op[2];
  assign div_signed = ~alu_op[0];

  // divider state
  logic [5:0]  cnt;
  logic        div_done;
  logic        sign1, sign2;
  logic [31:0] div_b, div_q, div_r;

  assign es_ready_go    = ~is_div | div_done;
  assign io.es_allowin  = ~es_valid | (es_ready_go & io.ms_allowin);
  assign io.es2ms_valid = es_valid & es_ready_go;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      es_valid <= 1'b0;
    end else if (io.es_allowin) begin
      es_valid <= io.ds2es_valid;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ds_bus_r <= '0;
    end else if (io.ds2es_valid & io.es_allowin) begin
      ds_bus_r <= io.ds2es_bus;
    end
  end

  // single-cycle ALU
  logic [31:0] add_res, alu_res;
  assign add_res = src1 + src2;

  always_comb begin
    alu_res = add_res;
    case (alu_op)
      4'd1:    alu_res = src1 - src2;
      4'd2:    alu_res = {31'd0, $signed(src1) < $signed(src2)};
      4'd3:    alu_res = {31'd0, src1 < src2};
      4'd4:    alu_res = src1 & src2;
      4'd5:    alu_res = src1 | src2;
      4'd6:    alu_res = src1 ^ src2;
      4'd7:    alu_res = ~(src1 | src2);
      4'd8:    alu_res = src1 << src2[4:0];
      4'd9:    alu_res = src1 >> src2[4:0];
      4'd10:   alu_res = $unsigned($signed(src1) >>> src2[4:0]);
      4'd11:   alu_res = src2;
      default: alu_res = add_res;
    endcase
  end

  // Restoring step: shift the next dividend bit into the partial remainder
  // and subtract the divisor if it fits. The 33-bit difference's top bit
  // is the borrow.
  logic [32:0] shifted, diff;
  assign shifted = {div_r, div_q[31]};
  assign diff    = shifted - {1'b0, div_b};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      div_done <= 1'b0;
      sign1    <= 1'b0;
      sign2    <= 1'b0;
      div_b    <= '0;
      div_q    <= '0;
      div_r    <= '0;
    end else if (io.es2ms_valid & io.ms_allowin) begin
      cnt      <= '0;
      div_done <= 1'b0;
    end else if (es_valid & is_div & ~div_done) begin
      if (cnt == 6'd0) begin
        sign1 <= div_signed & src1[31];
        sign2 <= div_signed & src2[31];
        div_q <= (div_signed & src1[31]) ? -src1 : src1;
        div_b <= (div_signed & src2[31]) ? -src2 : src2;
        div_r <= '0;
        cnt   <= 6'd1;
      end else begin
        if (!diff[32]) begin
          div_r <= diff[31:0];
          div_q <= {div_q[30:0], 1'b1};
        end else begin
          div_r <= shifted[31:0];
          div_q <= {div_q[30:0], 1'b0};
        end
        cnt <= cnt + 6'd1;
        if (cnt == 6'd32) div_done <= 1'b1;
      end
    end
  end

  // Sign fix-up. Divide by zero is overridden explicitly; the signed
  // overflow case falls out of magnitude arithmetic naturally.
  logic [31:0] quo_final, rem_final, result;
  always_comb begin
    quo_final = (sign1 ^ sign2) ? -div_q : div_q;
    rem_final = sign1 ? -div_r : div_r;
    if (div_b == 32'd0) begin
      quo_final = 32'hFFFF_FFFF;
      rem_final = src1;
    end
  end

  assign result = is_div ? (alu_op[1] ? rem_final : quo_final) : alu_res;

  // memory side
  logic [3:0]  mem_re, st_be;
  logic [31:0] st_wdata;
  always_comb begin
    mem_re   = 4'h0;
    st_be    = 4'hf;
    st_wdata = st_data;
    case (mem_size)
      2'd0: begin
        st_be    = 4'b0001 << add_res[1:0];
        st_wdata = {4{st_data[7:0]}};
        mem_re   = 4'h1;
      end
      2'd1: begin
        st_be    = 4'b0011 << {add_res[1], 1'b0};
        st_wdata = {2{st_data[15:0]}};
        mem_re   = 4'h3;
      end
      default: mem_re = 4'hf;
    endcase
    if (!res_from_mem) mem_re = 4'h0;
  end

  // Request only in the handoff cycle so load data lines up with MEM.
  assign io.data_sram_en    = es_valid & es_ready_go & io.ms_allowin &
                              (mem_we | res_from_mem);
  assign io.data_sram_we    = (io.data_sram_en & mem_we) ? st_be : 4'h0;
  assign io.data_sram_addr  = add_res;
  assign io.data_sram_wdata = st_wdata;

  assign io.es2ms_bus = {res_from_mem, mem_sign, mem_re, rf_we, rf_waddr,
                         result, pc};

  // A load's value or an unfinished divide cannot be forwarded yet.
  assign io.es_rf_zip = {es_valid & (res_from_mem | ~es_ready_go),
                         rf_we & es_valid, rf_waddr, result};

  assign io.dbg_cnt      = cnt;
  assign io.dbg_div_done = div_done;
endmodule
